// File: rtl/cr_kme_hmac_tag_check_pkg.sv
// Shared types and constants for the HMAC tag checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cr_kme_hmac_tag_check_pkg;

  localparam int TAG_W      = 256;
  localparam int TAG_BEAT_W = 128;

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    WAIT_EXP,
    RESULT
  } tag_chk_state_e;

  typedef struct packed {
    logic             pass;
    logic             short;
    logic             overrun;
    logic [TAG_W-1:0] tag;
  } tag_chk_result_t;

  // Short tags only carry the upper half; an overrun can never pass.
  function automatic logic tag_match(input logic [TAG_W-1:0] tag,
                                     input logic [TAG_W-1:0] exp,
                                     input logic             short_only,
                                     input logic             overrun);
    if (overrun) return 1'b0;
    if (short_only) return tag[TAG_W-1 -: TAG_BEAT_W] == exp[TAG_W-1 -: TAG_BEAT_W];
    return tag == exp;
  endfunction

endpackage

// File: rtl/cr_kme_hmac_tag_check_if.sv
// Tag-beat, expected-tag and result buses of the HMAC tag checker.
// Latency: n/a (wiring only).
// Backpressure: sha_tag_stall toward the engine, chk_stall from the consumer.
interface cr_kme_hmac_tag_check_if;
  import cr_kme_hmac_tag_check_pkg::*;

  logic                  sha_tag_valid;
  logic                  sha_tag_last;
  logic [TAG_BEAT_W-1:0] sha_tag_data;
  logic                  sha_tag_stall;

  logic                  exp_tag_valid;
  logic [TAG_W-1:0]      exp_tag_data;
  logic                  exp_tag_ack;

  logic                  chk_valid;
  logic                  chk_stall;
  logic                  chk_pass;
  logic                  chk_short;
  logic                  chk_overrun;
  logic [TAG_W-1:0]      chk_tag;

  modport master (
    output sha_tag_valid, sha_tag_last, sha_tag_data, exp_tag_valid, exp_tag_data, chk_stall,
    input  sha_tag_stall, exp_tag_ack, chk_valid, chk_pass, chk_short, chk_overrun, chk_tag
  );

  modport slave (
    input  sha_tag_valid, sha_tag_last, sha_tag_data, exp_tag_valid, exp_tag_data, chk_stall,
    output sha_tag_stall, exp_tag_ack, chk_valid, chk_pass, chk_short, chk_overrun, chk_tag
  );

endinterface

// File: rtl/cr_kme_hmac_tag_check_sat_cnt.sv
// Saturating up-counter for pass/fail statistics.
// Latency: count visible one cycle after inc.
// Backpressure: none; holds at all-ones.
module cr_kme_hmac_tag_check_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cr_kme_hmac_tag_check.sv
// Collects 2x128b tag beats, pops the expected tag, presents one pass/fail per tag.
// Latency: last beat at N -> exp_tag_ack at N+1 -> chk_valid at N+2.
// Backpressure: sha_tag_stall high from last beat until result handshake. Option: CR_KME_TAG_CHK_STATS_EN.
module cr_kme_hmac_tag_check
  import cr_kme_hmac_tag_check_pkg::*;
#(
  parameter int MAX_BEATS = 2,
  parameter int CNT_W     = 16
) (
  input logic                    clk,
  input logic                    rst,
  cr_kme_hmac_tag_check_if.slave bus
`ifdef CR_KME_TAG_CHK_STATS_EN
  ,
  output logic [CNT_W-1:0]       stat_pass_cnt,
  output logic [CNT_W-1:0]       stat_fail_cnt
`endif
);

  tag_chk_state_e  state, state_nxt;
  logic            cnt, cnt_nxt;
  tag_chk_result_t res, res_nxt;
  logic            stall, ack, beat_acc, hs;

  // Index of the final legal beat; a non-last beat here means the tag overran.
  localparam logic LAST_IDX = 1'(MAX_BEATS - 1);

  assign beat_acc = bus.sha_tag_valid & ~bus.sha_tag_stall;
  assign hs       = (state == RESULT) & ~bus.chk_stall;

  // State, beat counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      res   <= res_nxt;
    end
  end

  // Next-state, beat capture, compare and handshake outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_nxt   = res;
    stall     = 1'b0;
    ack       = 1'b0;
    case (state)
      COLLECT: begin
        if (beat_acc) begin
          if (cnt == 1'b0) res_nxt.tag[TAG_W-1 -: TAG_BEAT_W] = bus.sha_tag_data;
          else             res_nxt.tag[TAG_BEAT_W-1:0]        = bus.sha_tag_data;
          cnt_nxt = 1'b1;
          if (bus.sha_tag_last) begin
            res_nxt.short = (cnt == 1'b0);
            state_nxt     = WAIT_EXP;
          end else if (cnt == LAST_IDX) begin
            res_nxt.overrun = 1'b1;
            state_nxt       = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat_acc && bus.sha_tag_last) state_nxt = WAIT_EXP;
      end
      WAIT_EXP: begin
        stall = 1'b1;
        if (bus.exp_tag_valid) begin
          ack          = 1'b1;
          res_nxt.pass = tag_match(res.tag, bus.exp_tag_data, res.short, res.overrun);
          state_nxt    = RESULT;
        end
      end
      RESULT: begin
        stall = 1'b1;
        if (!bus.chk_stall) begin
          cnt_nxt   = 1'b0;
          res_nxt   = '0;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Never pop the FIFO or stall the engine while reset is applied.
  assign bus.sha_tag_stall = stall & ~rst;
  assign bus.exp_tag_ack   = ack & ~rst;
  assign bus.chk_valid     = (state == RESULT);
  assign bus.chk_pass      = res.pass;
  assign bus.chk_short     = res.short;
  assign bus.chk_overrun   = res.overrun;
  assign bus.chk_tag       = res.tag;

`ifdef CR_KME_TAG_CHK_STATS_EN
  cr_kme_hmac_tag_check_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hs & res.pass),
    .cnt (stat_pass_cnt)
  );

  cr_kme_hmac_tag_check_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hs & ~res.pass),
    .cnt (stat_fail_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_cr_kme_hmac_tag_check.sv
// Directed self-checking bench for cr_kme_hmac_tag_check.
// Latency: checks ack at N+1 and result at N+2 after the last beat.
// Backpressure: exercises exp_tag_valid low, chk_stall high and beats offered while stalled.
module tb_cr_kme_hmac_tag_check;
  import cr_kme_hmac_tag_check_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;

  localparam logic [127:0] HI  = {16{8'hA5}};
  localparam logic [127:0] LO  = {16{8'h5A}};
  localparam logic [127:0] DED = {8{16'hDEAD}};
  localparam logic [127:0] RND = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] XTR = {4{32'hFFFF0000}};

  cr_kme_hmac_tag_check_if bus();

`ifdef CR_KME_TAG_CHK_STATS_EN
  logic [15:0] stat_pass_cnt, stat_fail_cnt;
  cr_kme_hmac_tag_check dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .stat_pass_cnt (stat_pass_cnt),
    .stat_fail_cnt (stat_fail_cnt)
  );
`else
  cr_kme_hmac_tag_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.exp_tag_ack) ack_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until it transfers.
  task automatic send_beat(input logic [127:0] d, input logic last);
    int n = 0;
    bus.sha_tag_valid = 1'b1;
    bus.sha_tag_data  = d;
    bus.sha_tag_last  = last;
    while (bus.sha_tag_stall && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("beat_timeout", bus.sha_tag_stall, 0);
    step();
    bus.sha_tag_valid = 1'b0;
    bus.sha_tag_last  = 1'b0;
  endtask

  // Called in cycle N+1 after the last beat: ack now, result next cycle.
  task automatic expect_result(input string nm, input logic pass, input logic shrt,
                               input logic ovr, input logic [255:0] tag);
    check({nm, "_ack"}, bus.exp_tag_ack, 1);
    check({nm, "_vld_early"}, bus.chk_valid, 0);
    step();
    check({nm, "_vld"}, bus.chk_valid, 1);
    check({nm, "_ack_pulse"}, bus.exp_tag_ack, 0);
    check({nm, "_pass"}, bus.chk_pass, pass);
    check({nm, "_short"}, bus.chk_short, shrt);
    check({nm, "_ovr"}, bus.chk_overrun, ovr);
    check({nm, "_tag"}, bus.chk_tag, tag);
  endtask

  initial begin
    bus.sha_tag_valid = 1'b0;
    bus.sha_tag_last  = 1'b0;
    bus.sha_tag_data  = '0;
    bus.exp_tag_valid = 1'b0;
    bus.exp_tag_data  = '0;
    bus.chk_stall     = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_stall", bus.sha_tag_stall, 0);
    check("rst_ack", bus.exp_tag_ack, 0);
    check("rst_vld", bus.chk_valid, 0);
    check("rst_pass", bus.chk_pass, 0);
    check("rst_short", bus.chk_short, 0);
    check("rst_ovr", bus.chk_overrun, 0);
    check("rst_tag", bus.chk_tag, 0);
    rst = 1'b0;
    step();

    // 1: matching two-beat tag
    ack_cnt = 0;
    bus.exp_tag_valid = 1'b1;
    bus.exp_tag_data  = {HI, LO};
    send_beat(HI, 1'b0);
    send_beat(LO, 1'b1);
    check("t1_stall", bus.sha_tag_stall, 1);
    expect_result("t1", 1'b1, 1'b0, 1'b0, {HI, LO});
    step();
    check("t1_done", bus.chk_valid, 0);
    check("t1_acks", ack_cnt, 1);

    // 2: bit0 of expected tag flipped
    bus.exp_tag_data = {HI, LO ^ 128'h1};
    send_beat(HI, 1'b0);
    send_beat(LO, 1'b1);
    expect_result("t2", 1'b0, 1'b0, 1'b0, {HI, LO});
    step();
`ifdef CR_KME_TAG_CHK_STATS_EN
    check("t2_stat_fail", stat_fail_cnt, 1);
    check("t2_stat_pass", stat_pass_cnt, 1);
`endif

    // 3: single short beat, lower half of expected is unrelated
    bus.exp_tag_data = {DED, RND};
    send_beat(DED, 1'b1);
    expect_result("t3", 1'b1, 1'b1, 1'b0, {DED, 128'h0});
    step();

    // 4: three beats, third dropped, pass forced low even though tag matches
    ack_cnt = 0;
    bus.exp_tag_data = {HI, LO};
    send_beat(HI, 1'b0);
    send_beat(LO, 1'b0);
    check("t4_drain_stall", bus.sha_tag_stall, 0);
    check("t4_drain_ack", bus.exp_tag_ack, 0);
    send_beat(XTR, 1'b1);
    expect_result("t4", 1'b0, 1'b0, 1'b1, {HI, LO});
    step();
    check("t4_acks", ack_cnt, 1);

    // 5: late expected tag, stalled consumer, engine offering a beat meanwhile
    ack_cnt = 0;
    bus.exp_tag_valid = 1'b0;
    send_beat(HI, 1'b0);
    send_beat(LO, 1'b1);
    bus.sha_tag_valid = 1'b1;
    bus.sha_tag_data  = XTR;
    for (int i = 0; i < 10; i++) begin
      check("t5_wait_stall", bus.sha_tag_stall, 1);
      check("t5_wait_ack", bus.exp_tag_ack, 0);
      step();
    end
    bus.chk_stall     = 1'b1;
    bus.exp_tag_valid = 1'b1;
    #1;
    check("t5_ack", bus.exp_tag_ack, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_vld", bus.chk_valid, 1);
      check("t5_hold_pass", bus.chk_pass, 1);
      check("t5_hold_tag", bus.chk_tag, {HI, LO});
      check("t5_hold_stall", bus.sha_tag_stall, 1);
      step();
    end
    bus.sha_tag_valid = 1'b0;
    bus.chk_stall     = 1'b0;
    step();
    check("t5_done", bus.chk_valid, 0);
    check("t5_acks", ack_cnt, 1);

    // 6: reset after beat0 discards it
    ack_cnt = 0;
    send_beat(RND, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_tag", bus.chk_tag, 0);
    check("t6_rst_acks", ack_cnt, 0);
    send_beat(HI, 1'b0);
    send_beat(LO, 1'b1);
    expect_result("t6", 1'b1, 1'b0, 1'b0, {HI, LO});
    step();
    check("t6_acks", ack_cnt, 1);

    // 7: reset while a result is held
    bus.chk_stall = 1'b1;
    send_beat(HI, 1'b0);
    send_beat(LO, 1'b1);
    step();
    check("t7_vld", bus.chk_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.chk_stall = 1'b0;
    check("t7_vld_drop", bus.chk_valid, 0);
    check("t7_pass_clr", bus.chk_pass, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
